// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding,
// default buffer address width and a small state-classification helper.
package acq_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 12;

    // Encodings are visible to the host through the State status port.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRETRIG = 3'd1;
    localparam logic [2:0] ST_ARMED   = 3'd2;
    localparam logic [2:0] ST_POST    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_PRETRIG = ST_PRETRIG,
        S_ARMED   = ST_ARMED,
        S_POST    = ST_POST,
        S_DONE    = ST_DONE
    } acq_state_t;

    // A capture is in progress (and the buffer is being written) in these states.
    function automatic logic state_is_busy(input acq_state_t s);
        return (s == S_PRETRIG) || (s == S_ARMED) || (s == S_POST);
    endfunction

endpackage

// File: rtl/acquisition_controller_addr_counter.sv
// Wrapping write-address counter for the circular sample buffer.
// Clear has priority over increment; the count wraps modulo 2^ADDR_WIDTH.
module acq_addr_counter
    import acq_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] count
);

    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] count_d;

    // Next address: restart at zero on clear, otherwise step after each write.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + ADDR_WIDTH'(1);
        end
    end

    // Address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/acquisition_controller.sv
// Capture sequencer: fills the pre-trigger window, arms, takes the trigger
// sample plus the post-trigger window, then parks in DONE reporting where
// the trigger sample was written. Every output comes straight from a flop.
module acquisition_controller
    import acq_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic                  Trigger,
    input  logic [ADDR_WIDTH-1:0] PreTrigCount,
    input  logic [ADDR_WIDTH-1:0] PostTrigCount,
    output logic                  Armed,
    output logic                  EnableRecording,
    output logic                  WriteEnable,
    output logic [ADDR_WIDTH-1:0] WriteAddr,
    output logic [ADDR_WIDTH-1:0] TriggerAddr,
    output logic                  Done,
    output logic                  Busy,
    output logic [2:0]            State
);

    acq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;        // remaining writes in PRETRIG/POST
    logic [ADDR_WIDTH-1:0] post_q, post_d;      // post-trigger count latched at Start
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic                  we_q, we_d;
    logic                  armed_q, armed_d;
    logic                  en_rec_q, en_rec_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  start_accept;
    logic                  trig_accept;
    logic [ADDR_WIDTH-1:0] addr;

    // The address advances after every cycle in which a write was strobed,
    // and restarts at zero when a new capture is accepted.
    acq_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_counter (
        .clk   (Clock),
        .rst   (Reset),
        .clear (start_accept),
        .inc   (we_q),
        .count (addr)
    );

    // Next-state, sample-count and output computation; outputs are derived
    // from the next state so they are registered alongside it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        post_d       = post_q;
        trig_addr_d  = trig_addr_q;
        start_accept = 1'b0;
        trig_accept  = 1'b0;

        if (Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        start_accept = 1'b1;
                        cnt_d        = PreTrigCount;
                        post_d       = PostTrigCount;
                        state_d      = (PreTrigCount != '0) ? S_PRETRIG : S_ARMED;
                    end
                end
                S_PRETRIG: begin
                    // cnt_q counts the writes still to do, including this cycle's.
                    if (cnt_q <= ADDR_WIDTH'(1)) begin
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt_q - ADDR_WIDTH'(1);
                    end
                end
                S_ARMED: begin
                    if (Trigger) begin
                        trig_accept = 1'b1;
                        trig_addr_d = addr;
                        if (post_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_POST;
                            cnt_d   = post_q;
                        end
                    end
                end
                S_POST: begin
                    if (cnt_q <= ADDR_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        we_d     = state_is_busy(state_d);
        busy_d   = state_is_busy(state_d);
        armed_d  = (state_d == S_ARMED);
        done_d   = (state_d == S_DONE);
        en_rec_d = (state_d == S_POST) || trig_accept;
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            post_q      <= '0;
            trig_addr_q <= '0;
            we_q        <= 1'b0;
            armed_q     <= 1'b0;
            en_rec_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            post_q      <= post_d;
            trig_addr_q <= trig_addr_d;
            we_q        <= we_d;
            armed_q     <= armed_d;
            en_rec_q    <= en_rec_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign Armed           = armed_q;
    assign EnableRecording = en_rec_q;
    assign WriteEnable     = we_q;
    assign WriteAddr       = addr;
    assign TriggerAddr     = trig_addr_q;
    assign Done            = done_q;
    assign Busy            = busy_q;
    assign State           = state_q;

endmodule

// File: tb/tb_acquisition_controller.sv
// Directed bench for acquisition_controller. Expected write addresses are
// queued when a capture is launched and popped whenever a write strobe is seen.
module tb_acquisition_controller;
    import acq_pkg::*;

    localparam int AW  = 12;
    localparam int AW4 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Default-width instance
    logic          start, abort, trig;
    logic [AW-1:0] pre, post;
    logic          armed, en_rec, we, done, busy;
    logic [AW-1:0] waddr, taddr;
    logic [2:0]    state;

    // Narrow instance for wrap-around
    logic           start4, abort4, trig4;
    logic [AW4-1:0] pre4, post4;
    logic           armed4, en_rec4, we4, done4, busy4;
    logic [AW4-1:0] waddr4, taddr4;
    logic [2:0]     state4;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0]  exp_q[$];
    logic [AW4-1:0] exp4_q[$];

    always #5 clk = ~clk;

    acquisition_controller #(.ADDR_WIDTH(AW)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .Abort(abort), .Trigger(trig),
        .PreTrigCount(pre), .PostTrigCount(post),
        .Armed(armed), .EnableRecording(en_rec), .WriteEnable(we),
        .WriteAddr(waddr), .TriggerAddr(taddr), .Done(done), .Busy(busy),
        .State(state)
    );

    acquisition_controller #(.ADDR_WIDTH(AW4)) dut4 (
        .Clock(clk), .Reset(rst), .Start(start4), .Abort(abort4), .Trigger(trig4),
        .PreTrigCount(pre4), .PostTrigCount(post4),
        .Armed(armed4), .EnableRecording(en_rec4), .WriteEnable(we4),
        .WriteAddr(waddr4), .TriggerAddr(taddr4), .Done(done4), .Busy(busy4),
        .State(state4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(AW'(first + i));
    endtask

    // Advance one clock, then compare any write strobes against the queues.
    task automatic tick();
        logic [AW-1:0]  e;
        logic [AW4-1:0] e4;
        @(posedge clk);
        #1;
        if (we !== 1'b0) begin
            chk("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(waddr), 32'(e));
                $display("write addr=%0h expected=%0h", waddr, e);
            end
        end
        if (we4 !== 1'b0) begin
            chk("write4_expected", 32'(exp4_q.size() > 0), 1);
            if (exp4_q.size() > 0) begin
                e4 = exp4_q.pop_front();
                chk("write4_addr", 32'(waddr4), 32'(e4));
                $display("write4 addr=%0h expected=%0h", waddr4, e4);
            end
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(ST_IDLE));
        chk({tag, "_we"},    32'(we), 0);
        chk({tag, "_armed"}, 32'(armed), 0);
        chk({tag, "_enrec"}, 32'(en_rec), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_taddr"}, 32'(taddr), 0);
    endtask

    initial begin
        start = 0; abort = 0; trig = 0; pre = '0; post = '0;
        start4 = 0; abort4 = 0; trig4 = 0; pre4 = '0; post4 = '0;

        // Reset values
        #3;
        chk_idle_zero("reset");
        chk("reset4_state", 32'(state4), 32'(ST_IDLE));
        chk("reset4_we", 32'(we4), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Pre=4, Post=3, trigger held from cycle 10
        pre = 4; post = 3; start = 1; push_range(0, 12);
        tick(); start = 0; pre = 7; post = 9;            // cycle 1
        chk("a_busy", 32'(busy), 1);
        chk("a_state_pre", 32'(state), 32'(ST_PRETRIG));
        chk("a_armed_pre", 32'(armed), 0);
        tick(); tick(); tick();                          // cycle 4
        chk("a_state_pre4", 32'(state), 32'(ST_PRETRIG));
        tick();                                          // cycle 5
        chk("a_state_armed", 32'(state), 32'(ST_ARMED));
        chk("a_armed", 32'(armed), 1);
        start = 1;
        tick(); start = 0;                               // cycle 6
        chk("a_start_ignored", 32'(state), 32'(ST_ARMED));
        tick(); tick(); tick();                          // cycle 9
        trig = 1;
        tick();                                          // cycle 10
        chk("a_taddr", 32'(taddr), 8);
        chk("a_armed_drop", 32'(armed), 0);
        chk("a_enrec", 32'(en_rec), 1);
        chk("a_state_post", 32'(state), 32'(ST_POST));
        tick(); tick();                                  // cycle 12
        chk("a_enrec_post", 32'(en_rec), 1);
        tick();                                          // cycle 13
        trig = 0;
        chk("a_done", 32'(done), 1);
        chk("a_we_done", 32'(we), 0);
        chk("a_busy_done", 32'(busy), 0);
        chk("a_state_done", 32'(state), 32'(ST_DONE));
        chk("a_taddr_held", 32'(taddr), 8);
        chk("a_drain", 32'(exp_q.size()), 0);

        // Start from DONE with Pre=0, Post=0
        pre = 0; post = 0; start = 1; push_range(0, 1);
        tick(); start = 0;
        chk("b_state_armed", 32'(state), 32'(ST_ARMED));
        chk("b_armed", 32'(armed), 1);
        chk("b_done_cleared", 32'(done), 0);
        trig = 1;
        tick(); trig = 0;
        chk("b_state_done", 32'(state), 32'(ST_DONE));
        chk("b_done", 32'(done), 1);
        chk("b_we", 32'(we), 0);
        chk("b_taddr", 32'(taddr), 0);
        chk("b_drain", 32'(exp_q.size()), 0);

        // Trigger pulses in PRETRIG and POST are ignored
        pre = 3; post = 2; start = 1; push_range(0, 7);
        tick(); start = 0;                               // cycle 1
        trig = 1;
        tick(); trig = 0;                                // cycle 2
        chk("c_pre_trig_ignored", 32'(state), 32'(ST_PRETRIG));
        chk("c_pre_enrec", 32'(en_rec), 0);
        tick(); tick();                                  // cycle 4
        chk("c_state_armed", 32'(state), 32'(ST_ARMED));
        tick();                                          // cycle 5
        trig = 1;
        tick(); trig = 0;                                // cycle 6
        chk("c_taddr", 32'(taddr), 4);
        chk("c_state_post", 32'(state), 32'(ST_POST));
        trig = 1;
        tick(); trig = 0;                                // cycle 7
        chk("c_post_trig_ignored", 32'(taddr), 4);
        chk("c_state_post2", 32'(state), 32'(ST_POST));
        tick();                                          // cycle 8
        chk("c_done", 32'(done), 1);
        chk("c_taddr_final", 32'(taddr), 4);
        chk("c_drain", 32'(exp_q.size()), 0);

        // Abort and Trigger together in ARMED
        pre = 1; post = 2; start = 1; push_range(0, 3);
        tick(); start = 0;                               // cycle 1
        tick();                                          // cycle 2
        chk("d_state_armed", 32'(state), 32'(ST_ARMED));
        tick();                                          // cycle 3
        abort = 1; trig = 1;
        tick(); abort = 0; trig = 0;                     // cycle 4
        chk("d_state_idle", 32'(state), 32'(ST_IDLE));
        chk("d_we", 32'(we), 0);
        chk("d_enrec", 32'(en_rec), 0);
        chk("d_armed", 32'(armed), 0);
        chk("d_busy", 32'(busy), 0);
        chk("d_taddr_held", 32'(taddr), 4);
        tick(); tick();
        chk("d_drain", 32'(exp_q.size()), 0);

        // Address wrap on the 4-bit instance
        pre4 = 2; post4 = 1; start4 = 1;
        for (int i = 0; i < 24; i++) exp4_q.push_back(AW4'(i % 16));
        tick(); start4 = 0;                              // cycle 1
        repeat (22) tick();                              // cycle 23
        chk("e_waddr_wrapped", 32'(waddr4), 6);
        trig4 = 1;
        tick(); trig4 = 0;                               // cycle 24
        chk("e_taddr", 32'(taddr4), 6);
        chk("e_state_post", 32'(state4), 32'(ST_POST));
        tick();                                          // cycle 25
        chk("e_done", 32'(done4), 1);
        chk("e_we", 32'(we4), 0);
        chk("e_drain", 32'(exp4_q.size()), 0);

        // Asynchronous reset in the middle of POST
        pre = 0; post = 5; start = 1; push_range(0, 3);
        tick(); start = 0;                               // cycle 1
        trig = 1;
        tick(); trig = 0;                                // cycle 2
        chk("f_state_post", 32'(state), 32'(ST_POST));
        tick();                                          // cycle 3
        #2 rst = 1'b1;
        #1;
        chk_idle_zero("f_async");
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("f_state_after", 32'(state), 32'(ST_IDLE));
        chk("f_drain", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acquisition_controller.md
# acquisition_controller

Sequencer for one capture in the fast acquisition path. On a host Start command it fills a programmable number of pre-trigger samples into the circular sample buffer, arms the trigger, captures a programmable number of post-trigger samples, then stops and reports where the trigger landed. It drives the buffer write port and the `Armed`/`EnableRecording` handshake that the trigger logic consumes.

## Interface
- `ADDR_WIDTH`, 12, sample buffer address width; depth is 2^ADDR_WIDTH.
- `Clock`  in  1  sample clock; the only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  single-cycle command; begins a capture from IDLE or DONE.
- `Abort`  in  1  single-cycle command; returns to IDLE from any state.
- `Trigger`  in  1  trigger event, already synchronous to `Clock`.
- `PreTrigCount`  in  ADDR_WIDTH  pre-trigger samples; latched on accepted Start.
- `PostTrigCount`  in  ADDR_WIDTH  samples after the trigger sample; latched on accepted Start.
- `Armed`  out  1  high in ARMED only.
- `EnableRecording`  out  1  high from the trigger-accept cycle through the end of POST.
- `WriteEnable`  out  1  buffer write strobe.
- `WriteAddr`  out  ADDR_WIDTH  buffer write address.
- `TriggerAddr`  out  ADDR_WIDTH  address written in the trigger-accept cycle.
- `Done`  out  1  high in DONE.
- `Busy`  out  1  high in PRETRIG, ARMED, POST.
- `State`  out  3  current state encoding, for status readback.

## Operation
- States: IDLE, PRETRIG, ARMED, POST, DONE. All outputs registered.
- Reset values: state IDLE. `Armed`, `EnableRecording`, `WriteEnable`, `Done`, `Busy` = 0. `WriteAddr`, `TriggerAddr` = 0.
- IDLE or DONE, with `Start` and no `Abort`:
  - latch both counts; `WriteAddr` <= 0; clear `Done`.
  - Go to PRETRIG if `PreTrigCount` != 0, else ARMED.
- `Start` in PRETRIG, ARMED or POST is ignored.
- PRETRIG:
  - `WriteEnable`=1 for exactly PreTrigCount cycles, with `WriteAddr` incrementing each write.
  - `Trigger` is ignored.
  - Moves to ARMED after the last pre-trigger write.
- ARMED:
  - `WriteEnable`=1 every cycle; the address wraps modulo 2^ADDR_WIDTH with no limit on dwell time.
  - On `Trigger`, that cycle's write is the trigger sample. Its address is latched into `TriggerAddr`, `EnableRecording` rises, and the next state is POST, or DONE if PostTrigCount==0.
- POST:
  - exactly PostTrigCount further writes, then DONE.
  - `EnableRecording` stays high; `Trigger` is ignored.
- DONE: `WriteEnable`=0, `Done`=1, `TriggerAddr` held; remains until `Start` or `Abort`.
- `Abort`, in any state:
  - next state IDLE; `WriteEnable`, `Armed` and `EnableRecording` drop on the next edge.
  - `TriggerAddr` is held.
  - Abort wins over a simultaneous `Start` or `Trigger`.
- Address arithmetic is unsigned and wraps at 2^ADDR_WIDTH. If PreTrigCount+PostTrigCount+1 exceeds the depth, the oldest samples are overwritten. No error is flagged; the host is responsible for choosing counts.
- `Reset` mid-capture returns to the reset values immediately (asynchronous); no partial state survives.

## Timing
- `Start` sampled at edge N: `Busy`=1 and the first `WriteEnable` at edge N+1, with `WriteAddr`=0 in that cycle.
- `Trigger` sampled at edge T while in ARMED:
  - that cycle's `WriteAddr` is latched into `TriggerAddr`.
  - `Armed`=0 and `EnableRecording`=1 from edge T+1.
- Last post-trigger write occurs in cycle T+PostTrigCount. `Done`=1 from the following edge, in the same cycle `WriteEnable` drops.
- The count in each state is exact: no extra or missing write cycle at any state boundary.

## Structure
- Shared package/include `acq_pkg`: state encoding localparams (IDLE=0, PRETRIG=1, ARMED=2, POST=3, DONE=4) and the `ADDR_WIDTH` default.
- One natural sub-module, `acq_addr_counter`: wrapping ADDR_WIDTH counter with clear and increment-enable, driving `WriteAddr`.
- Down-counter for the PRETRIG/POST sample counts lives in the top FSM.

## Test plan
- Reset asserted mid-POST -> all outputs 0 and `State`=IDLE in the same cycle; no writes after release until `Start`.
- Pre=4, Post=3; Start, then Trigger held from cycle 10:
  - writes to addresses 0..3 in PRETRIG.
  - ARMED writes continue until the trigger.
  - `TriggerAddr` equals the write address in the trigger cycle.
  - exactly 3 further writes, then `Done`=1 with `WriteEnable`=0.
- Pre=0, Post=0; Start, then Trigger -> ARMED directly at N+1; the single trigger write at address 0; DONE the next cycle.
- Trigger pulses during PRETRIG and during POST -> ignored; `TriggerAddr` is set only by the ARMED trigger.
- ADDR_WIDTH=4, Pre=2, trigger after 20 ARMED cycles -> `WriteAddr` wraps 15->0; `TriggerAddr`=(2+20)%16=6.
- Abort and Trigger in the same ARMED cycle -> IDLE, `EnableRecording` stays 0. Start in DONE -> a new capture begins at address 0.
